// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_pkg
//  Description : Shared definitions for the sequential shift-add multiplier:
//                FSM state encoding and the index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Ceiling log2. A result of at least 1 keeps the index register non-empty.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_abs.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_abs
//  Description : Combinational conditional two's-complement negate. Used for
//                operand magnitudes and for the final product sign fix-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Negation wraps in WIDTH bits, so the most negative value maps onto
    // its own bit pattern, which read as unsigned is the correct magnitude.
    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult
//  Description : Parametrised sequential shift-add multiplier with valid/ready
//                handshakes, optional signed mode and optional early
//                termination. One multiplier bit is consumed per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_TERM = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int IDX_W = clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_acc;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [PW-1:0]    r_product;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod_next;
    logic [WIDTH-1:0] w_rest;
    logic             w_last;

    // Operand magnitudes; negation only applies to negative signed operands
    seq_mult_abs #(.WIDTH(WIDTH)) u_a_abs (
        .value  (a),
        .negate (sgn & a[WIDTH-1]),
        .result (w_a_mag)
    );

    seq_mult_abs #(.WIDTH(WIDTH)) u_b_abs (
        .value  (b),
        .negate (sgn & b[WIDTH-1]),
        .result (w_b_mag)
    );

    // Partial product for the current multiplier bit, aligned to its weight
    assign w_addend   = r_mplier[r_idx] ? ({{WIDTH{1'b0}}, r_mcand} << r_idx) : '0;
    assign w_acc_next = r_acc + w_addend;

    // Multiplier bits above the current one; the shift is done at 32 bits so
    // idx+1 == WIDTH cannot wrap in the narrow index width.
    assign w_rest = r_mplier >> (32'(r_idx) + 32'd1);
    assign w_last = (r_idx == IDX_W'(WIDTH - 1)) ||
                    ((EARLY_TERM != 0) && (w_rest == '0));

    // Final sign correction of the magnitude product
    seq_mult_abs #(.WIDTH(PW)) u_p_neg (
        .value  (w_acc_next),
        .negate (r_neg),
        .result (w_prod_next)
    );

    // Control FSM plus accumulator, index and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (clr) begin
            // Abort discards the in-flight operation but keeps the last product
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_product <= w_prod_next;
                        r_state   <= DONE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult
//  Description : Self-checking bench for seq_mult. Two WIDTH=8 instances, one
//                without and one with early termination, share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        sgn = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, busy0;
    logic [15:0] product0;
    logic        in_ready1, out_valid1, busy1;
    logic [15:0] product1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(8), .EARLY_TERM(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready0), .a(a), .b(b), .sgn(sgn),
        .out_valid(out_valid0), .out_ready(out_ready),
        .product(product0), .busy(busy0)
    );

    seq_mult #(.WIDTH(8), .EARLY_TERM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready1), .a(a), .b(b), .sgn(sgn),
        .out_valid(out_valid1), .out_ready(out_ready),
        .product(product1), .busy(busy1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y, input logic s);
        int ix, iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        return 16'(ix * iy);
    endfunction

    // Early-termination latency: highest set bit of |b| plus one, zero takes 1
    function automatic int ref_lat1(input logic [7:0] y, input logic s);
        int m, l;
        m = (s && y[7]) ? (256 - int'(y)) : int'(y);
        l = 1;
        for (int k = 0; k < 8; k++) begin
            if (((m >> k) & 1) == 1) l = k + 1;
        end
        return l;
    endfunction

    // One full transaction on both instances with out_ready held high
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                         input logic [15:0] ep, input int el1, input string nm);
        int  n;
        bit  seen0, seen1;
        @(negedge clk);
        check({nm, ".in_ready"}, {31'd0, in_ready0 & in_ready1}, 32'd1);
        a = ta; b = tb; sgn = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
        n = 0; seen0 = 0; seen1 = 0;
        while (!(seen0 && seen1) && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!seen0 && out_valid0) begin
                seen0 = 1;
                check({nm, ".prod0"}, {16'd0, product0}, {16'd0, ep});
                check({nm, ".lat0"}, n, 8);
            end
            if (!seen1 && out_valid1) begin
                seen1 = 1;
                check({nm, ".prod1"}, {16'd0, product1}, {16'd0, ep});
                check({nm, ".lat1"}, n, el1);
            end
        end
        if (!(seen0 && seen1)) check({nm, ".timeout"}, {30'd0, seen1, seen0}, 32'd3);
    endtask

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        vs;
        logic [15:0] ep;
        int          lat1;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int         n;
        bit         flag;
        logic [7:0] ra, rb;
        logic       rs;

        vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, 4};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, 8};
        vecs[2] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 3};
        vecs[3] = '{8'h80,  8'h80,  1'b1, 16'h4000, 8};
        vecs[4] = '{8'h80,  8'h7F,  1'b1, 16'hC080, 7};
        vecs[5] = '{8'd7,   8'd3,   1'b0, 16'h0015, 2};
        vecs[6] = '{8'h5A,  8'd0,   1'b0, 16'h0000, 1};
        vecs[7] = '{8'h01,  8'h80,  1'b0, 16'h0080, 8};
        vecs[8] = '{8'd3,   8'h80,  1'b1, 16'hFE80, 8};
        vecs[9] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, 1};

        // Reset state while rst_n is held low
        #2;
        check("rst.in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst.out_valid", {31'd0, out_valid0 | out_valid1}, 32'd0);
        check("rst.busy", {31'd0, busy0 | busy1}, 32'd0);
        check("rst.product", {16'd0, product0 | product1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].ep, vecs[i].lat1, $sformatf("vec%0d", i));
        end

        // Randomised operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i % 3 == 0) rb = rb >> $urandom_range(0, 7);
            do_op(ra, rb, rs, ref_prod(ra, rb, rs), ref_lat1(rb, rs), $sformatf("rnd%0d", i));
        end

        // Back-pressure: hold the result for 5 cycles, then release
        @(negedge clk);
        out_ready = 1'b0; a = 8'd6; b = 8'd7; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check("bp.valid_rise", {31'd0, out_valid0}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_prod", {16'd0, product0}, 32'h002A);
            check("bp.hold_valid", {31'd0, out_valid0}, 32'd1);
            check("bp.hold_in_ready", {31'd0, in_ready0}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp.release_valid", {31'd0, out_valid0}, 32'd0);
        check("bp.release_in_ready", {31'd0, in_ready0}, 32'd1);
        a = 8'd9; b = 8'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.reaccept_busy", {31'd0, busy0}, 32'd1);
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check("bp.second_prod", {16'd0, product0}, 32'h0051);
        repeat (2) @(posedge clk);

        // Abort at idx=3: no result, product keeps the previous value
        @(negedge clk);
        a = 8'd5; b = 8'hFF; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("clr.busy_before", {31'd0, busy0 & busy1}, 32'd1);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check("clr.in_ready", {31'd0, in_ready0 & in_ready1}, 32'd1);
        check("clr.busy", {31'd0, busy0 | busy1}, 32'd0);
        check("clr.product_kept", {16'd0, product0}, 32'h0051);
        flag = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid0 || out_valid1) flag = 1;
        end
        check("clr.no_valid", {31'd0, flag}, 32'd0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'd5; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.product", {16'd0, product0 | product1}, 32'd0);
        check("arst.busy", {31'd0, busy0 | busy1}, 32'd0);
        check("arst.in_ready", {31'd0, in_ready0 & in_ready1}, 32'd1);
        check("arst.out_valid", {31'd0, out_valid0 | out_valid1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd2, 8'd2, 1'b0, 16'h0004, 2, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
